// File: rtl/parking_occupancy_ctrl_if.sv
// Event and display bundle between the detector, the occupancy controller
// and the BCD-to-SSEG decoder. The controller is the slave side.
interface parking_occupancy_ctrl_if;
   logic       inc;
   logic       dec;
   logic       clear;
   logic [7:0] count_bcd;
   logic       full;
   logic       empty;
   logic       overflow_err;
   logic       underflow_err;
   logic [1:0] digit_sel;
   logic [3:0] digit_bcd;

   modport master (
      output inc, dec, clear,
      input  count_bcd, full, empty, overflow_err, underflow_err,
      input  digit_sel, digit_bcd
   );

   modport slave (
      input  inc, dec, clear,
      output count_bcd, full, empty, overflow_err, underflow_err,
      output digit_sel, digit_bcd
   );
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// Parking-lot occupancy controller: two-digit BCD count bounded by CAPACITY,
// full/empty decode, sticky over/underflow flags, and a two-digit display scan.
// Optional build macro PARKING_BLANK_LEAD_EN: blank (4'hF) a zero tens digit.
//
// Scan FSM
//   state     | meaning
//   SCAN_ONES | ones digit driven, digit_sel = 01
//   SCAN_TENS | tens digit driven, digit_sel = 10
module parking_occupancy_ctrl #(
   parameter int CAPACITY = 50,
   parameter int SCAN_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    async_reset_n,
   parking_occupancy_ctrl_if.slave bus
);

   if (CAPACITY < 1 || CAPACITY > 99) begin : g_bad_capacity
      $error("parking_occupancy_ctrl: CAPACITY must be 1..99");
   end
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("parking_occupancy_ctrl: SCAN_DIV must be at least 2");
   end

   localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [7:0] CAP_BCD = {4'(CAPACITY / 10), 4'(CAPACITY % 10)};

   typedef enum logic [1:0] {
      SCAN_ONES = 2'b01,
      SCAN_TENS = 2'b10
   } scan_state_t;

   logic [3:0]        tens;
   logic [3:0]        ones;
   logic              overflow_q;
   logic              underflow_q;
   logic              is_full;
   logic              is_empty;
   logic [SCAN_W-1:0] scan_cnt;
   scan_state_t       scan_state;
   logic [3:0]        digit_mux;

   assign is_full  = ({tens, ones} == CAP_BCD);
   assign is_empty = ({tens, ones} == 8'h00);

   // Occupancy count and sticky error flags; clear beats simultaneous events,
   // which beat a single event.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         tens        <= 4'h0;
         ones        <= 4'h0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clear) begin
         tens        <= 4'h0;
         ones        <= 4'h0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.inc && bus.dec) begin
         tens <= tens;
         ones <= ones;
      end else if (bus.inc) begin
         if (is_full) begin
            overflow_q <= 1'b1;
         end else if (ones == 4'd9) begin
            ones <= 4'd0;
            tens <= tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end else if (bus.dec) begin
         if (is_empty) begin
            underflow_q <= 1'b1;
         end else if (ones == 4'd0) begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
         end else begin
            ones <= ones - 4'd1;
         end
      end
   end

   // Free-running scan divider; each terminal count hands the display to the other digit.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         scan_cnt   <= '0;
         scan_state <= SCAN_ONES;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt   <= '0;
         scan_state <= (scan_state == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
      end else begin
         scan_cnt   <= scan_cnt + 1'b1;
      end
   end

   // Digit value mux for the currently selected digit.
   always_comb begin
      digit_mux = ones;
      if (scan_state == SCAN_TENS) begin
`ifdef PARKING_BLANK_LEAD_EN
         digit_mux = (tens == 4'h0) ? 4'hF : tens;
`else
         digit_mux = tens;
`endif
      end
   end

   assign bus.count_bcd     = {tens, ones};
   assign bus.full          = is_full;
   assign bus.empty         = is_empty;
   assign bus.overflow_err  = overflow_q;
   assign bus.underflow_err = underflow_q;
   assign bus.digit_sel     = scan_state;
   assign bus.digit_bcd     = digit_mux;

endmodule

// File: doc/parking_occupancy_ctrl.md
# parking_occupancy_ctrl

Occupancy controller for the parking-lot design. It consumes the debounced, edge-detected `inc`/`dec` event pulses from the detector and keeps a two-digit BCD occupancy count bounded by a configured capacity. It reports full, empty and sticky error conditions. It also time-multiplexes the count onto a two-digit seven-segment driver by scheduling digit selection. It sits between the detector and the BCD-to-SSEG decoder.

## Interface

- `CAPACITY`, default 50: lot capacity, legal range 1..99; out of range is an elaboration error.
- `SCAN_DIV`, default 50000: clock cycles each digit is held during display scan; minimum 2.

- `clk`  in  1  single system clock; all state rises on its positive edge.
- `async_reset_n`  in  1  reset, asynchronous, active-low; asserts immediately and releases on the next clock edge.
- `inc`  in  1  one-cycle car-entered pulse.
- `dec`  in  1  one-cycle car-left pulse.
- `clear`  in  1  synchronous clear of count and error flags.
- `count_bcd`  out  8  occupancy; [7:4] tens, [3:0] ones, BCD.
- `full`  out  1  high when count equals `CAPACITY`.
- `empty`  out  1  high when count equals 0.
- `overflow_err`  out  1  sticky; an `inc` arrived while full.
- `underflow_err`  out  1  sticky; a `dec` arrived while empty.
- `digit_sel`  out  2  one-hot, active-high; 01 selects ones, 10 selects tens.
- `digit_bcd`  out  4  BCD value for the currently selected digit.

## Operation

- Event priority each cycle: `clear` > (`inc` and `dec` together) > single event.
- `clear`: count goes to 0 and both error flags go to 0; `inc`/`dec` in the same cycle are ignored.
- `inc` and `dec` together: count is unchanged and no error is raised, even when full or empty.
- `inc` alone:
  - count < `CAPACITY`: BCD +1; ones 9 wraps to 0 and carries into tens.
  - count == `CAPACITY`: count holds and `overflow_err` is set.
- `dec` alone:
  - count > 0: BCD −1; ones 0 wraps to 9 and borrows from tens.
  - count == 0: count holds and `underflow_err` is set.
- The count never leaves 0..`CAPACITY` and never holds a non-BCD nibble.
- Error flags stay set until `clear` or reset.
- `full` and `empty` are decoded from the count register. Both are low for any count strictly between 0 and `CAPACITY`. When `CAPACITY` is 1, count 1 drives `full` high and count 0 drives `empty` high.
- Scan scheduler:
  - A free-running counter runs 0..`SCAN_DIV`−1 and is independent of events.
  - On terminal count it wraps to 0 and `digit_sel` toggles between 01 and 10.
  - `digit_sel` is never 00 or 11.
- `digit_bcd` is a combinational mux of the count register, selected by `digit_sel`.

## Timing

- Reset values:
  - `count_bcd` 8'h00, `empty` 1, `full` 0, both error flags 0.
  - `digit_sel` 2'b01, scan counter 0, `digit_bcd` 4'h0.
- Latency: an event sampled at edge N is reflected in `count_bcd`, `full`, `empty` and the error flags after edge N (one-cycle latency).
- Back-to-back `inc` pulses on consecutive cycles are each counted; there is no recovery time.
- `digit_sel` holds for exactly `SCAN_DIV` cycles per digit; a full two-digit refresh takes 2×`SCAN_DIV` cycles.
- `digit_bcd` follows a count change in the same cycle the count register updates.
- Reset mid-operation: all state returns to reset values asynchronously, and the scan restarts on ones.
- Events whose sampling edge falls inside reset are lost.

## Configuration

- `PARKING_BLANK_LEAD_EN`:
  - Defined: leading-zero blanking is on. When `digit_sel` is 10 and the tens nibble is 0, `digit_bcd` outputs 4'hF (the SSEG decoder's blank code).
  - Undefined: `digit_bcd` always carries the tens nibble, so a zero tens digit shows as 0.
- `count_bcd` is identical in both builds.

## Test plan

- Reset, then 12 single `inc` pulses -> `count_bcd` 8'h12, `empty` 0, `full` 0, no errors; the 10th pulse yields 8'h10, checking ones carry.
- `CAPACITY`=50, count 8'h50, one more `inc` -> count stays 8'h50, `full` 1, `overflow_err` 1; then `dec` -> 8'h49, `full` 0, `overflow_err` still 1.
- Count 0, `dec` -> `underflow_err` 1, count 8'h00; then `inc` and `dec` on the same cycle at count 8'h20 -> 8'h20 and no new error; then `clear` together with `inc` -> 8'h00 and both flags 0.
- Count 8'h10, single `dec` -> 8'h09, checking borrow; `async_reset_n` low mid-cycle -> all outputs reach reset values before the next edge.
- `SCAN_DIV`=4, count 8'h07 -> `digit_sel` alternates 01/10 every 4 cycles.
  - `digit_bcd` is 4'h7 while 01 is selected.
  - While 10 is selected, `digit_bcd` is 4'h0 without `PARKING_BLANK_LEAD_EN` and 4'hF with it.
- Random `inc`/`dec`/`clear` over 10k cycles against a reference model -> count always matches, is valid BCD, and stays ≤ `CAPACITY`.
